// File: rtl/fix_rx_framer.sv
// fix_rx_framer: delimits FIX messages in the TOE receive stream, forwards them with one cycle
// of latency, checks the tag-10 trailer, and aborts/resyncs on malformed input. Macro: FIX_RX_CKSUM_EN.
module fix_rx_framer #(
  parameter int NUM_HOST = 2,
  parameter int MAX_LEN  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  input  logic [NUM_HOST-1:0] id_i,
  output logic [7:0]          message_o,
  output logic                message_valid_o,
  output logic                new_message_o,
  output logic                eom_o,
  output logic                checksum_ok_o,
  output logic                abort_o,
  output logic [NUM_HOST-1:0] msg_id_o
);
  localparam int               LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [7:0]       SOH     = 8'h01;
  localparam logic [7:0]       EQ      = 8'h3d;
  localparam logic [7:0]       START   = 8'h38;

  typedef enum logic [1:0] {IDLE, TAG, VALUE, CK} state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] len;
  logic [6:0]       tag_acc;
  logic [1:0]       ck_cnt;
  logic             is_digit, is_soh, is_eq;
  logic [3:0]       digit;
  logic [10:0]      tag_prod;
  logic [6:0]       tag_next;
  logic             fmt_bad, start_c, abort_c, fwd_c, eom_c, ck_match;

  assign is_digit = (byte_i >= 8'h30) && (byte_i <= 8'h39);
  assign is_soh   = (byte_i == SOH);
  assign is_eq    = (byte_i == EQ);
  assign digit    = byte_i[3:0];
  assign tag_prod = 11'(tag_acc) * 11'd10 + 11'(digit);
  assign tag_next = (tag_prod > 11'd127) ? 7'd127 : tag_prod[6:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (abort_c) begin
      state_d = IDLE;
    end else if (fwd_c) begin
      case (state)
        IDLE:    state_d = TAG;
        TAG:     if (is_eq) state_d = (tag_acc == 7'd10) ? CK : VALUE;
        VALUE:   if (is_soh) state_d = TAG;
        default: if (is_soh) state_d = IDLE;
      endcase
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fmt_bad = 1'b0;
    case (state)
      TAG:     fmt_bad = !(is_digit || is_eq);
      CK:      fmt_bad = is_digit ? (ck_cnt == 2'd3) : !(is_soh && ck_cnt == 2'd3);
      default: fmt_bad = 1'b0;
    endcase
    start_c = byte_valid_i && (state == IDLE) && (byte_i == START);
    abort_c = byte_valid_i && (state != IDLE) &&
              (fmt_bad || (id_i != msg_id_o) || (len == LEN_MAX));
    fwd_c   = start_c || (byte_valid_i && (state != IDLE) && !abort_c);
    eom_c   = fwd_c && (state == CK) && is_soh;
  end

`ifdef FIX_RX_CKSUM_EN
  logic [7:0] sum, snap;
  logic [9:0] ck;

  // snap captures the running sum at each SOH; the last one before "10=" is the checksum target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= 8'd0;
      snap <= 8'd0;
      ck   <= 10'd0;
    end else if (start_c) begin
      sum  <= START;
      snap <= 8'd0;
      ck   <= 10'd0;
    end else if (fwd_c) begin
      if (state != CK) sum <= sum + byte_i;
      if (state == VALUE && is_soh) snap <= sum + byte_i;
      if (state == CK && is_digit) ck <= ck * 10'd10 + 10'(digit);
    end
  end

  assign ck_match = (ck == {2'b00, snap});
`else
  assign ck_match = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      message_o       <= 8'd0;
      message_valid_o <= 1'b0;
      new_message_o   <= 1'b0;
      eom_o           <= 1'b0;
      checksum_ok_o   <= 1'b0;
      abort_o         <= 1'b0;
      msg_id_o        <= '0;
      len             <= '0;
      tag_acc         <= 7'd0;
      ck_cnt          <= 2'd0;
    end else begin
      message_valid_o <= 1'b0;
      new_message_o   <= 1'b0;
      eom_o           <= 1'b0;
      checksum_ok_o   <= 1'b0;
      abort_o         <= 1'b0;
      if (fwd_c) begin
        message_o       <= byte_i;
        message_valid_o <= 1'b1;
        len             <= start_c ? LEN_W'(1) : len + LEN_W'(1);
      end
      if (start_c) begin
        new_message_o <= 1'b1;
        msg_id_o      <= id_i;
        tag_acc       <= 7'd8;
        ck_cnt        <= 2'd0;
      end else if (fwd_c) begin
        if (state == TAG && is_digit)  tag_acc <= tag_next;
        if (state == VALUE && is_soh)  tag_acc <= 7'd0;
        if (state == CK && is_digit)   ck_cnt  <= ck_cnt + 2'd1;
      end
      if (eom_c) begin
        eom_o         <= 1'b1;
        checksum_ok_o <= ck_match;
      end
      if (abort_c) abort_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fix_rx_framer.sv
// Scoreboard bench for fix_rx_framer: two instances (MAX_LEN 26 and 16) share one random byte
// stream; a message-level reference model predicts each output event.
module tb_fix_rx_framer;
  typedef struct packed {
    logic [7:0] b;
    logic       fwd, nm, eom, ok, ab;
    logic [1:0] id;
  } exp_t;

`ifdef FIX_RX_CKSUM_EN
  localparam int CK_ON = 1;
`else
  localparam int CK_ON = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, byte_valid_i = 1'b0;
  logic [7:0] byte_i = 8'd0;
  logic [1:0] id_i = 2'd0;
  logic [7:0] m_msg [2];
  logic [1:0] m_id  [2];
  logic [1:0] m_valid, m_new, m_eom, m_ok, m_ab;

  always #5 clk = ~clk;

  fix_rx_framer #(.NUM_HOST(2), .MAX_LEN(26)) u_dut26 (
    .clk(clk), .rst_n(rst_n), .byte_valid_i(byte_valid_i), .byte_i(byte_i), .id_i(id_i),
    .message_o(m_msg[0]), .message_valid_o(m_valid[0]), .new_message_o(m_new[0]),
    .eom_o(m_eom[0]), .checksum_ok_o(m_ok[0]), .abort_o(m_ab[0]), .msg_id_o(m_id[0]));

  fix_rx_framer #(.NUM_HOST(2), .MAX_LEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .byte_valid_i(byte_valid_i), .byte_i(byte_i), .id_i(id_i),
    .message_o(m_msg[1]), .message_valid_o(m_valid[1]), .new_message_o(m_new[1]),
    .eom_o(m_eom[1]), .checksum_ok_o(m_ok[1]), .abort_o(m_ab[1]), .msg_id_o(m_id[1]));

  int         max_len [2] = '{26, 16};
  logic [7:0] mbuf [2][0:1023];
  int         mlen [2] = '{0, 0};
  int         fstart [2] = '{0, 0};
  bit         mopen [2] = '{0, 0};
  logic [1:0] mid [2] = '{2'd0, 2'd0};
  exp_t       q0[$], q1[$];
  int         total = 0, bad = 0;
  int         n_eom [2] = '{0, 0}, n_ok [2] = '{0, 0}, n_ab [2] = '{0, 0};
  int         b_eom [2] = '{0, 0}, b_ok [2] = '{0, 0}, b_ab [2] = '{0, 0};
  string      clean_s = "8=FIX.4.2|9=5|35=0|10=161|";
  string      badck_s = "8=FIX.4.2|9=5|35=0|10=162|";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_dig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Reference model: judges each byte by the field it lands in (tag text, value text, or the
  // three-digit trailer) and computes the checksum from the stored message at the end.
  task automatic model_byte(input int k, input logic [7:0] b, input logic [1:0] id);
    exp_t e;
    int   eq_pos, tagv, nd;
    bit   reject, fin;
    e = '0;
    e.id = mid[k];
    reject = 1'b0;
    fin = 1'b0;
    eq_pos = -1;
    if (!mopen[k]) begin
      if (b != 8'h38) return;
      mopen[k] = 1'b1; mlen[k] = 0; fstart[k] = 0; mid[k] = id;
      e.id = id; e.nm = 1'b1;
    end else begin
      for (int i = fstart[k]; i < mlen[k]; i++)
        if (eq_pos < 0 && mbuf[k][i] == 8'h3d) eq_pos = i;
      if (eq_pos < 0) begin
        reject = !(is_dig(b) || b == 8'h3d);
      end else begin
        tagv = 0;
        for (int i = fstart[k]; i < eq_pos; i++) begin
          tagv = tagv * 10 + (int'(mbuf[k][i]) - 48);
          if (tagv > 1000) tagv = 1000;
        end
        if (tagv == 10) begin
          nd = mlen[k] - eq_pos - 1;
          if (is_dig(b))                 reject = (nd >= 3);
          else if (b == 8'h01 && nd == 3) fin = 1'b1;
          else                           reject = 1'b1;
        end
      end
      if (id != mid[k] || mlen[k] >= max_len[k]) reject = 1'b1;
    end
    if (reject) begin
      e.ab = 1'b1;
      mopen[k] = 1'b0;
      push(k, e);
      return;
    end
    mbuf[k][mlen[k]] = b;
    mlen[k]++;
    e.fwd = 1'b1;
    e.b = b;
    if (fin) begin
      e.eom = 1'b1;
`ifdef FIX_RX_CKSUM_EN
      begin
        int sum, ck;
        sum = 0;
        for (int i = 0; i < fstart[k]; i++) sum += int'(mbuf[k][i]);
        ck = 0;
        for (int i = eq_pos + 1; i <= eq_pos + 3; i++) ck = ck * 10 + (int'(mbuf[k][i]) - 48);
        e.ok = (ck == sum % 256);
      end
`else
      e.ok = 1'b1;
`endif
      mopen[k] = 1'b0;
    end else if (b == 8'h01) begin
      fstart[k] = mlen[k];
    end
    push(k, e);
  endtask

  task automatic mon(input int k, input logic [7:0] mo, input logic v, input logic nm,
                     input logic eo, input logic ok, input logic ab, input logic [1:0] id);
    exp_t e;
    if (!(v | nm | eo | ab)) return;
    n_eom[k] += int'(eo);
    n_ok[k]  += int'(eo & ok);
    n_ab[k]  += int'(ab);
    if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      check($sformatf("spurious_event%0d", k), {28'd0, v, nm, eo, ab}, 32'd0);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("valid%0d", k), v, e.fwd);
    check($sformatf("new%0d", k), nm, e.nm);
    check($sformatf("eom%0d", k), eo, e.eom);
    check($sformatf("abort%0d", k), ab, e.ab);
    check($sformatf("msg_id%0d", k), id, e.id);
    if (e.fwd) check($sformatf("byte%0d", k), mo, e.b);
    if (e.eom) check($sformatf("cksum_ok%0d", k), ok, e.ok);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, m_msg[0], m_valid[0], m_new[0], m_eom[0], m_ok[0], m_ab[0], m_id[0]);
      mon(1, m_msg[1], m_valid[1], m_new[1], m_eom[1], m_ok[1], m_ab[1], m_id[1]);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic [1:0] id);
    if ($urandom_range(7, 0) == 0) begin
      @(posedge clk); #1 byte_valid_i = 1'b0;
    end
    @(posedge clk); #1;
    byte_valid_i = 1'b1; byte_i = b; id_i = id;
    model_byte(0, b, id);
    model_byte(1, b, id);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1 byte_valid_i = 1'b0;
    end
  endtask

  task automatic send_msg(input string s, input logic [1:0] id, input int bad_pos = -1,
                          input logic [7:0] bad_b = 8'd0, input int id_pos = -1,
                          input logic [1:0] id2 = 2'd0, input int stop = 10000);
    logic [7:0] b;
    for (int i = 0; i < s.len() && i < stop; i++) begin
      b = (s[i] == 8'h7c) ? 8'h01 : s[i];
      if (i == bad_pos) b = bad_b;
      send_byte(b, (id_pos >= 0 && i >= id_pos) ? id2 : id);
    end
  endtask

  function automatic string rand_msg(input bit wrong);
    string s;
    int    sum, ck, nf, vl, t;
    s = ($urandom_range(1, 0) == 1) ? "8=FIX.4.2|" : "8=F|";
    nf = $urandom_range(2, 0);
    for (int f = 0; f < nf; f++) begin
      t = $urandom_range(99, 1);
      if (t == 10) t = 11;
      s = {s, $sformatf("%0d=", t)};
      vl = $urandom_range(3, 1);
      for (int c = 0; c < vl; c++) s = {s, $sformatf("%c", 8'($urandom_range(8'h5a, 8'h41)))};
      s = {s, "|"};
    end
    sum = 0;
    for (int i = 0; i < s.len(); i++) sum += (s[i] == 8'h7c) ? 1 : int'(s[i]);
    ck = sum % 256;
    if (wrong) ck = ck + $urandom_range(255, 1);
    return {s, $sformatf("10=%03d|", ck)};
  endfunction

  task automatic mark();
    for (int k = 0; k < 2; k++) begin
      b_eom[k] = n_eom[k]; b_ok[k] = n_ok[k]; b_ab[k] = n_ab[k];
    end
  endtask

  task automatic expect_counts(input string name, input int k, input int de, input int dok,
                               input int dab);
    idle(3);
    check($sformatf("%s_eom_count%0d", name, k), n_eom[k] - b_eom[k], de);
    check($sformatf("%s_ok_count%0d", name, k), n_ok[k] - b_ok[k], dok);
    check($sformatf("%s_abort_count%0d", name, k), n_ab[k] - b_ab[k], dab);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_message%0d", tag, k), m_msg[k], 0);
      check($sformatf("%s_valid%0d", tag, k), m_valid[k], 0);
      check($sformatf("%s_new%0d", tag, k), m_new[k], 0);
      check($sformatf("%s_eom%0d", tag, k), m_eom[k], 0);
      check($sformatf("%s_ok%0d", tag, k), m_ok[k], 0);
      check($sformatf("%s_abort%0d", tag, k), m_ab[k], 0);
      check($sformatf("%s_id%0d", tag, k), m_id[k], 0);
    end
  endtask

  initial begin
    string s;
    int    mode;
    idle(2);
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    mark(); send_msg(clean_s, 2'd1);
    expect_counts("clean", 0, 1, 1, 0); expect_counts("clean", 1, 0, 0, 1);

    mark(); send_msg(badck_s, 2'd1);
    expect_counts("badck", 0, 1, 1 - CK_ON, 0); expect_counts("badck", 1, 0, 0, 1);

    mark(); send_byte(8'h41, 2'd1); send_byte(8'h42, 2'd1); send_msg(clean_s, 2'd1);
    expect_counts("resync", 0, 1, 1, 0);

    mark(); send_msg(clean_s, 2'd1, -1, 8'd0, 9, 2'd2);
    expect_counts("idchange", 0, 0, 0, 1); expect_counts("idchange", 1, 0, 0, 1);

    send_msg(clean_s, 2'd1, -1, 8'd0, -1, 2'd0, 12);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    byte_valid_i = 1'b0;
    q0.delete(); q1.delete();
    mopen[0] = 1'b0; mopen[1] = 1'b0; mid[0] = 2'd0; mid[1] = 2'd0;
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    mark(); send_msg(clean_s, 2'd1);
    expect_counts("after_reset", 0, 1, 1, 0);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(2, 0)) send_byte(8'($urandom_range(255, 1)), 2'($urandom));
      s = rand_msg($urandom_range(3, 0) == 0);
      mode = $urandom_range(9, 0);
      if (mode == 7)
        send_msg(s, 2'($urandom), $urandom_range(s.len() - 1, 1), 8'($urandom));
      else if (mode == 8)
        send_msg(s, 2'd0, -1, 8'd0, $urandom_range(s.len() - 1, 1), 2'd3);
      else
        send_msg(s, 2'($urandom));
    end
    idle(5);
    check("drain_queue0", q0.size(), 0);
    check("drain_queue1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
